// File: rtl/branch_recovery_ctrl_if.sv
// Front-end branch tag / recovery bundle between decode, branch resolution and the freelist.
// master is the recovery controller side; slave is the surrounding front end.
interface branch_recovery_ctrl_if #(
    parameter int unsigned MAX_PREDICT_DEPTH      = 4,
    parameter int unsigned MAX_PREDICT_DEPTH_BITS = $clog2(MAX_PREDICT_DEPTH)
);
    logic                              tag_req;
    logic                              tag_grant;
    logic [MAX_PREDICT_DEPTH_BITS-1:0] tag_out;
    logic                              tags_full;
    logic                              resolve_valid;
    logic [MAX_PREDICT_DEPTH_BITS-1:0] resolve_tag;
    logic                              resolve_mispredict;
    logic                              branch_shootdown;
    logic [MAX_PREDICT_DEPTH_BITS-1:0] shootdown_branch_tag;
    logic                              clear;
    logic                              recovering;
    logic [MAX_PREDICT_DEPTH-1:0]      inflight;

    modport master (
        input  tag_req,
        input  resolve_valid,
        input  resolve_tag,
        input  resolve_mispredict,
        output tag_grant,
        output tag_out,
        output tags_full,
        output branch_shootdown,
        output shootdown_branch_tag,
        output clear,
        output recovering,
        output inflight
    );

    modport slave (
        output tag_req,
        output resolve_valid,
        output resolve_tag,
        output resolve_mispredict,
        input  tag_grant,
        input  tag_out,
        input  tags_full,
        input  branch_shootdown,
        input  shootdown_branch_tag,
        input  clear,
        input  recovering,
        input  inflight
    );
endinterface

// File: rtl/branch_recovery_ctrl.sv
// Branch tag allocator and misprediction recovery sequencer: hands out tags in ring order,
// frees them on resolve, and on a mispredict squashes younger tags, pulses shootdown and drains.
module branch_recovery_ctrl #(
    parameter int unsigned MAX_PREDICT_DEPTH      = 4,
    parameter int unsigned MAX_PREDICT_DEPTH_BITS = $clog2(MAX_PREDICT_DEPTH),
    parameter int unsigned DRAIN_CYCLES           = 2
) (
    input logic                    clk,
    input logic                    reset,
    branch_recovery_ctrl_if.master fe_io
);
    localparam int unsigned Depth = MAX_PREDICT_DEPTH;
    localparam int unsigned TagW  = MAX_PREDICT_DEPTH_BITS;

    typedef logic [TagW-1:0] tag_t;
    typedef enum logic [1:0] {StIdle, StShoot, StDrain} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    tag_t             head_q, head_d;
    tag_t             stag_q, stag_d;
    logic [Depth-1:0] inflight_q, inflight_d;
    logic [Depth-1:0] squash_mask;
    logic [TagW:0]    span;
    logic             res_acc;
    logic             misp_acc;
    logic             tags_full;
    logic             grant;

    assign res_acc   = fe_io.resolve_valid & inflight_q[fe_io.resolve_tag];
    assign misp_acc  = res_acc & fe_io.resolve_mispredict;
    assign tags_full = inflight_q[head_q];
    assign grant     = fe_io.tag_req & ~tags_full & (state_q == StIdle) & ~misp_acc;

    // Tags from resolve_tag up to head-1 (ring order); head == resolve_tag means the ring is full.
    always_comb begin
        squash_mask = '0;
        span        = {1'b0, tag_t'(head_q - fe_io.resolve_tag)};
        if (span == '0) begin
            span = (TagW + 1)'(Depth);
        end
        for (int unsigned i = 0; i < Depth; i++) begin
            squash_mask[i] = ({1'b0, tag_t'(tag_t'(i) - fe_io.resolve_tag)} < span);
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        head_d     = head_q;
        stag_d     = stag_q;
        if (res_acc && !fe_io.resolve_mispredict) begin
            inflight_d[fe_io.resolve_tag] = 1'b0;
        end
        if (grant) begin
            inflight_d[head_q] = 1'b1;
            head_d             = head_q + tag_t'(1);
        end
        if (misp_acc) begin
            inflight_d = inflight_q & ~squash_mask;
            head_d     = fe_io.resolve_tag;
            stag_d     = fe_io.resolve_tag;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (misp_acc) begin
                    state_d = StShoot;
                end
            end
            StShoot: begin
                if (misp_acc) begin
                    state_d = StShoot;
                end else begin
                    state_d = StDrain;
                    cnt_d   = 4'(DRAIN_CYCLES);
                end
            end
            StDrain: begin
                if (misp_acc) begin
                    state_d = StShoot;
                end else if (cnt_q == 4'd1) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            head_q     <= '0;
            stag_q     <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            stag_q     <= stag_d;
            inflight_q <= inflight_d;
        end
    end

    assign fe_io.tag_grant            = grant;
    assign fe_io.tag_out              = head_q;
    assign fe_io.tags_full            = tags_full;
    assign fe_io.branch_shootdown     = (state_q == StShoot);
    assign fe_io.shootdown_branch_tag = stag_q;
    assign fe_io.clear                = (state_q != StIdle);
    assign fe_io.recovering           = (state_q != StIdle);
    assign fe_io.inflight             = inflight_q;
endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Randomized scoreboard bench for branch_recovery_ctrl against a countdown-based reference model.
module tb_branch_recovery_ctrl;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned BW    = 2;
    localparam int unsigned DRAIN = 2;
    localparam int unsigned NCYC  = 4000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_recovery_ctrl_if #(.MAX_PREDICT_DEPTH(DEPTH)) fe_if ();

    branch_recovery_ctrl #(
        .MAX_PREDICT_DEPTH(DEPTH),
        .DRAIN_CYCLES     (DRAIN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .fe_io(fe_if)
    );

    typedef struct packed {
        logic             grant;
        logic [BW-1:0]    tag;
        logic             full;
        logic [DEPTH-1:0] inflight;
        logic             shoot;
        logic [BW-1:0]    stag;
        logic             clr;
        logic             rec;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: busy flags, allocation head, last shot tag, cycles of recovery left.
    bit busy[DEPTH];
    int head;
    int stag;
    int rec_left;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) busy[i] = 1'b0;
        head     = 0;
        stag     = 0;
        rec_left = 0;
    endtask

    task automatic model_step(input bit rst, input bit req, input bit rv, input int rt,
                              input bit rm);
        exp_t e;
        bit   acc;
        bit   misp;
        int   t;
        acc  = rv && busy[rt];
        misp = acc && rm;
        e.grant = req && !busy[head] && (rec_left == 0) && !misp;
        e.tag   = BW'(head);
        e.full  = busy[head];
        for (int i = 0; i < DEPTH; i++) e.inflight[i] = busy[i];
        e.shoot = (rec_left == DRAIN + 1);
        e.stag  = BW'(stag);
        e.clr   = (rec_left > 0);
        e.rec   = (rec_left > 0);
        exp_q.push_back(e);
        if (rec_left > 0) rec_left--;
        if (acc && !rm) busy[rt] = 1'b0;
        if (e.grant) begin
            busy[head] = 1'b1;
            head       = (head + 1) % DEPTH;
        end
        if (misp) begin
            t = rt;
            do begin
                busy[t] = 1'b0;
                t       = (t + 1) % DEPTH;
            end while (t != head);
            head     = rt;
            stag     = rt;
            rec_left = DRAIN + 1;
        end
        if (rst) model_reset();
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: outputs are valid every cycle once stimulus settles.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tag_grant", int'(fe_if.tag_grant), int'(e.grant));
                check("tag_out", int'(fe_if.tag_out), int'(e.tag));
                check("tags_full", int'(fe_if.tags_full), int'(e.full));
                check("inflight", int'(fe_if.inflight), int'(e.inflight));
                check("branch_shootdown", int'(fe_if.branch_shootdown), int'(e.shoot));
                check("shootdown_branch_tag", int'(fe_if.shootdown_branch_tag), int'(e.stag));
                check("clear", int'(fe_if.clear), int'(e.clr));
                check("recovering", int'(fe_if.recovering), int'(e.rec));
            end
        end
    end

    initial begin
        int busy_list[$];
        int phase;
        int rt;
        bit rv;
        bit rm;
        reset                    = 1'b1;
        fe_if.tag_req            = 1'b0;
        fe_if.resolve_valid      = 1'b0;
        fe_if.resolve_tag        = '0;
        fe_if.resolve_mispredict = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        for (int c = 0; c < int'(NCYC); c++) begin
            @(negedge clk);
            phase = (c / 200) % 3;
            reset = ($urandom_range(0, 149) == 0);
            fe_if.tag_req = ($urandom_range(0, 3) != 0);
            case (phase)
                0:       rv = ($urandom_range(0, 7) == 0);
                1:       rv = ($urandom_range(0, 1) == 0);
                default: rv = ($urandom_range(0, 7) != 0);
            endcase
            busy_list.delete();
            for (int i = 0; i < DEPTH; i++) if (busy[i]) busy_list.push_back(i);
            if (busy_list.size() > 0 && $urandom_range(0, 3) != 0)
                rt = busy_list[$urandom_range(0, busy_list.size() - 1)];
            else
                rt = $urandom_range(0, DEPTH - 1);
            rm = (phase == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
            fe_if.resolve_valid      = rv;
            fe_if.resolve_tag        = BW'(rt);
            fe_if.resolve_mispredict = rm;
            #1;
            model_step(reset, fe_if.tag_req, rv, rt, rm);
        end
        @(negedge clk);
        reset               = 1'b0;
        fe_if.tag_req       = 1'b0;
        fe_if.resolve_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_recovery_ctrl.md
# branch_recovery_ctrl

Controller that owns speculative branch tags and sequences misprediction recovery for the rename/decode front end. It hands out branch tags to decode in strict allocation order, frees them as branches resolve, and on a mispredict drives a one-cycle `branch_shootdown` with `shootdown_branch_tag` to the physical-register freelist. It then holds `clear` on the decode/rename pipeline for a fixed drain window before releasing the front end. It sits between the branch resolution unit and the `uop_decode`/freelist pair.

## Interface
Parameters:
- `MAX_PREDICT_DEPTH`, 4: number of branch tags, a power of two ≥ 2.
- `MAX_PREDICT_DEPTH_BITS`, `$clog2(MAX_PREDICT_DEPTH)`: tag width.
- `DRAIN_CYCLES`, 2: cycles `clear` stays high after the shootdown cycle; range 1..15.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `tag_req` in 1: decode requests a tag for a branch this cycle.
- `tag_grant` out 1: tag granted this cycle (combinational).
- `tag_out` out MAX_PREDICT_DEPTH_BITS: granted tag; equals `head`.
- `tags_full` out 1: tag at `head` is still in flight.
- `resolve_valid` in 1: a branch resolved this cycle.
- `resolve_tag` in MAX_PREDICT_DEPTH_BITS: tag of the resolving branch.
- `resolve_mispredict` in 1: the resolving branch mispredicted.
- `branch_shootdown` out 1: registered one-cycle pulse to the freelist.
- `shootdown_branch_tag` out MAX_PREDICT_DEPTH_BITS: registered tag being shot down.
- `clear` out 1: registered flush to decode/rename.
- `recovering` out 1: state ≠ IDLE.
- `inflight` out MAX_PREDICT_DEPTH: in-flight tag bitmask, for debug and verification.

## Operation
State:
- `head` pointer, `inflight` mask, FSM {IDLE, SHOOT, DRAIN}, drain counter.
- All state is reset to 0 / IDLE.
- Output reset values: `branch_shootdown`=0, `shootdown_branch_tag`=0, `clear`=0, `recovering`=0, `tags_full`=0, `inflight`=0.

Allocation:
- `tag_grant` = `tag_req` & !`tags_full` & state==IDLE & !(accepted mispredict this cycle).
- On grant: `inflight[head]` <= 1 and `head` <= `head`+1 (mod depth).
- Tags are strictly sequential; a free tag elsewhere does not unblock allocation while `inflight[head]` is set.

Resolution:
- A resolve is accepted only if `resolve_valid` & `inflight[resolve_tag]`. Any other resolve is ignored entirely.
- Correct prediction: `inflight[resolve_tag]` <= 0.
- Mispredict of tag T:
  - Clear `inflight` bits for T and every younger tag T+1 .. `head`-1 (mod depth).
  - `head` <= T.
  - `shootdown_branch_tag` <= T.
  - Next state is SHOOT.

FSM:
- IDLE: on an accepted mispredict, go to SHOOT.
- SHOOT:
  - `branch_shootdown`=1 and `clear`=1 for exactly one cycle.
  - Load the counter with `DRAIN_CYCLES`, then go to DRAIN.
- DRAIN:
  - `clear`=1; decrement the counter; go to IDLE when the counter reaches 1.
  - No grants during SHOOT or DRAIN.
  - Correct resolves are still processed.
- An accepted mispredict in SHOOT or DRAIN (necessarily an older surviving tag) restarts recovery: apply the squash rule above, then SHOOT next cycle.

Simultaneous events:
- A correct resolve and a grant in the same cycle both apply.
- If the granted tag equals `resolve_tag`, the resolve is not accepted, because the bit is not yet set.
- A mispredict in the same cycle as `tag_req` gives no grant.

## Timing
- `tag_grant` and `tag_out` are combinational in the request cycle; `inflight` and `tags_full` update at the next edge.
- Mispredict accepted at edge N:
  - `branch_shootdown` and `clear` go high in cycle N+1.
  - `clear` stays high through cycle N+1+`DRAIN_CYCLES`.
  - The first grant is possible in cycle N+2+`DRAIN_CYCLES`.
- `recovering` is high for exactly 1+`DRAIN_CYCLES` cycles per uninterrupted recovery.
- `reset` asserted mid-recovery drops `clear` and `branch_shootdown` at the next edge and empties `inflight`.

## Test plan
- Fill tags: after reset, hold `tag_req` 5 cycles (depth 4) -> grants with tags 0,1,2,3; `tags_full`=1 in the 5th cycle with no grant; `inflight`=4'b1111.
- Out-of-order free: in-flight {0,1,2,3} with `head`=0, resolve tag 2 correct -> `inflight`=4'b1011; `tags_full` stays 1; resolve tag 0 -> next `tag_req` granted tag 0.
- Mispredict squash: tags 0,1,2 in flight, `head`=3, mispredict tag 1 at edge N -> `inflight`=4'b0001; `head`=1; `branch_shootdown`=1 with tag 1 in cycle N+1 only; `clear` high cycles N+1..N+3; grant of tag 1 possible at N+4.
- Nested recovery: during DRAIN, mispredict surviving tag 0 -> `inflight`=0; `head`=0; a new SHOOT pulse with tag 0; `clear` extended a further 1+`DRAIN_CYCLES` cycles.
- Stale resolve: resolve tag 3 (mispredict=1) while `inflight[3]`=0 -> no state change, no shootdown.
- Reset mid-DRAIN: assert `reset` -> next cycle `clear`=0, `recovering`=0, `inflight`=0, `head`=0.
